// File: rtl/adc_sample_fifo.sv
// ADC sample buffer: converts unsigned 10-bit samples to signed offset form and
// queues them in a first-word-fall-through FIFO with a level and overflow report.
`timescale 1ns/1ps
module adc_sample_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [9:0]               adc_data,
    input  logic                     adc_valid,
    input  logic                     enable,
    input  logic                     flush,
    input  logic                     clear_ovf,
    output logic [9:0]               datain_V_dout,
    output logic                     datain_V_empty_n,
    input  logic                     datain_V_read,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_try;
    logic          rd_acc;
    logic          wr_acc;
    logic          drop;
    logic [LW-1:0] level_nxt;

    // level is the full/empty reference; pointers wrap naturally at DEPTH
    always_comb begin
        wr_try    = adc_valid && enable;
        rd_acc    = datain_V_read && datain_V_empty_n;
        wr_acc    = wr_try && (!full || rd_acc);
        drop      = wr_try && full && !rd_acc && !flush;
        level_nxt = level;
        if (flush)
            level_nxt = '0;
        else if (wr_acc && !rd_acc)
            level_nxt = level + LW'(1);
        else if (!wr_acc && rd_acc)
            level_nxt = level - LW'(1);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            level            <= '0;
            full             <= 1'b0;
            datain_V_empty_n <= 1'b0;
        end else begin
            level            <= level_nxt;
            full             <= (level_nxt == LW'(DEPTH));
            datain_V_empty_n <= (level_nxt != '0);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc)
                    wr_ptr <= wr_ptr + AW'(1);
                if (rd_acc)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // a drop in the same cycle as clear_ovf restarts the count at one
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_ovf)
                drop_cnt <= CNT_W'(1);
            else if (drop_cnt != '1)
                drop_cnt <= drop_cnt + CNT_W'(1);
        end else if (clear_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (wr_acc && !flush)
            mem[wr_ptr] <= {~adc_data[9], adc_data[8:0]};
    end

    always_comb begin
        datain_V_dout = '0;
        if (datain_V_empty_n)
            datain_V_dout = mem[rd_ptr];
    end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Randomised self-checking bench for adc_sample_fifo against a queue-based model.
`timescale 1ns/1ps
module tb_adc_sample_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic                ap_clk = 1'b0;
    logic                ap_rst_n = 1'b0;
    logic [9:0]          adc_data = '0;
    logic                adc_valid = 1'b0;
    logic                enable = 1'b0;
    logic                flush = 1'b0;
    logic                clear_ovf = 1'b0;
    logic [9:0]          datain_V_dout;
    logic                datain_V_empty_n;
    logic                datain_V_read = 1'b0;
    logic [4:0]          level;
    logic                full;
    logic                overflow;
    logic [CNT_W-1:0]    drop_cnt;

    adc_sample_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
        .enable(enable), .flush(flush), .clear_ovf(clear_ovf), .datain_V_dout(datain_V_dout),
        .datain_V_empty_n(datain_V_empty_n), .datain_V_read(datain_V_read), .level(level),
        .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: queue of signed sample values, sticky flag, drop count
    int q[$];
    bit m_ovf   = 1'b0;
    int m_drops = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dout_s();
        return int'($signed(datain_V_dout));
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".empty_n"}, int'(datain_V_empty_n), int'(q.size() != 0));
        check_val({tag, ".level"},   int'(level), q.size());
        check_val({tag, ".full"},    int'(full), int'(q.size() == DEPTH));
        check_val({tag, ".ovf"},     int'(overflow), int'(m_ovf));
        check_val({tag, ".drops"},   int'(drop_cnt), m_drops);
        check_val({tag, ".dout"},    dout_s(), (q.size() != 0) ? q[0] : 0);
    endtask

    task automatic model_update(input bit v, input bit en, input logic [9:0] d,
                                input bit rd, input bit fl, input bit clr);
        bit drop     = 1'b0;
        bit rd_ok    = rd && (q.size() > 0);
        bit was_full = (q.size() == DEPTH);
        if (fl) begin
            q.delete();
        end else begin
            if (rd_ok) void'(q.pop_front());
            if (v && en) begin
                if (!was_full || rd_ok) q.push_back(int'(d) - 512);
                else drop = 1'b1;
            end
        end
        if (clr) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end
        if (drop) begin
            m_ovf = 1'b1;
            if (m_drops < (1 << CNT_W) - 1) m_drops++;
        end
    endtask

    // inputs change just after a falling edge; outputs are checked on the next falling edge
    task automatic step(input string tag, input bit v, input bit en, input logic [9:0] d,
                        input bit rd, input bit fl, input bit clr);
        adc_valid     = v;
        enable        = en;
        adc_data      = d;
        datain_V_read = rd;
        flush         = fl;
        clear_ovf     = clr;
        @(posedge ap_clk);
        model_update(v, en, d, rd, fl, clr);
        @(negedge ap_clk);
        adc_valid     = 1'b0;
        enable        = 1'b0;
        datain_V_read = 1'b0;
        flush         = 1'b0;
        clear_ovf     = 1'b0;
        check_outputs(tag);
    endtask

    task automatic wr(input string tag, input logic [9:0] d);
        step(tag, 1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input string tag);
        step(tag, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          conv_in [4]  = '{0, 512, 1023, 700};
        int          conv_exp [4] = '{-512, 0, 511, 188};
        int          first16 [16];
        int          hist[$];
        logic [9:0]  d;
        int          saved_drops;

        repeat (2) @(negedge ap_clk);
        check_outputs("reset");
        ap_rst_n = 1'b1;

        // conversion and one-cycle visibility
        for (int i = 0; i < 4; i++) begin
            wr("conv_w", 10'(conv_in[i]));
            if (i == 0) check_val("conv_visible", dout_s(), -512);
        end
        for (int i = 0; i < 4; i++) begin
            check_val("conv_rd", dout_s(), conv_exp[i]);
            rd("conv_r");
        end

        // fill beyond capacity
        for (int i = 0; i < 20; i++) begin
            d = 10'($urandom_range(1023));
            if (i < 16) first16[i] = int'(d) - 512;
            wr("fill", d);
            if (i == 15) check_val("full_at_16", int'(full), 1);
        end
        check_val("fill_ovf", int'(overflow), 1);
        check_val("fill_drops", int'(drop_cnt), 4);
        for (int i = 0; i < 16; i++) begin
            check_val("fill_rd", dout_s(), first16[i]);
            rd("fill_r");
        end
        check_val("fill_empty", int'(datain_V_empty_n), 0);
        step("clr", 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
        check_val("clr_ovf", int'(overflow), 0);
        check_val("clr_drops", int'(drop_cnt), 0);

        // full with simultaneous write and read
        for (int i = 0; i < 16; i++) wr("refill", 10'($urandom_range(1023)));
        step("full_wr_rd", 1'b1, 1'b1, 10'($urandom_range(1023)), 1'b1, 1'b0, 1'b0);
        check_val("full_wr_rd_level", int'(level), 16);
        check_val("full_wr_rd_drops", int'(drop_cnt), 0);
        for (int i = 0; i < 16; i++) rd("drain");

        // empty edge cases
        rd("empty_rd");
        check_val("empty_rd_level", int'(level), 0);
        step("empty_wr_rd", 1'b1, 1'b1, 10'd300, 1'b1, 1'b0, 1'b0);
        check_val("empty_wr_rd_level", int'(level), 1);
        check_val("empty_wr_rd_dout", dout_s(), 300 - 512);
        rd("drain1");

        // wrap-around streaming with a preload of three
        for (int i = 0; i < 3; i++) begin
            d = 10'($urandom_range(1023));
            hist.push_back(int'(d) - 512);
            wr("preload", d);
        end
        for (int i = 0; i < 100; i++) begin
            d = 10'($urandom_range(1023));
            check_val("wrap_dout", dout_s(), hist[i]);
            hist.push_back(int'(d) - 512);
            step("wrap", 1'b1, 1'b1, d, 1'b1, 1'b0, 1'b0);
            check_val("wrap_level", int'(level), 3);
        end
        check_val("wrap_ovf", int'(overflow), 0);
        for (int i = 0; i < 3; i++) rd("wrap_drain");

        // flush concurrent with a write, after creating some drops
        for (int i = 0; i < 18; i++) wr("pre_flush_fill", 10'($urandom_range(1023)));
        for (int i = 0; i < 7; i++) rd("pre_flush_rd");
        check_val("pre_flush_level", int'(level), 9);
        saved_drops = m_drops;
        step("flush", 1'b1, 1'b1, 10'd77, 1'b0, 1'b1, 1'b0);
        check_val("flush_level", int'(level), 0);
        check_val("flush_empty", int'(datain_V_empty_n), 0);
        check_val("flush_drops", int'(drop_cnt), saved_drops);
        wr("post_flush_w", 10'd900);
        check_val("post_flush_dout", dout_s(), 388);
        rd("post_flush_r");

        // asynchronous reset mid-stream at level 5
        for (int i = 0; i < 5; i++) wr("pre_rst", 10'($urandom_range(1023)));
        check_val("pre_rst_level", int'(level), 5);
        #2 ap_rst_n = 1'b0;
        #1;
        check_val("rst_empty", int'(datain_V_empty_n), 0);
        check_val("rst_level", int'(level), 0);
        check_val("rst_full", int'(full), 0);
        check_val("rst_ovf", int'(overflow), 0);
        check_val("rst_drops", int'(drop_cnt), 0);
        check_val("rst_dout", dout_s(), 0);
        q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step("post_rst_idle", 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        check_val("post_rst_empty", int'(datain_V_empty_n), 0);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            step("rand",
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) != 0,
                 10'($urandom_range(1023)),
                 $urandom_range(0, 9) < 4,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 39) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_fifo.md
# adc_sample_fifo

Producer-side sample buffer feeding the `mov_sum` edge-trigger datapath through its `ap_fifo` read port (`datain_V_dout` / `datain_V_empty_n` / `datain_V_read`). It accepts raw unsigned 10-bit ADC samples, converts them to signed offset form (sample − 512), and buffers them in a circular first-word-fall-through FIFO. It also reports fill level and sticky overflow status with a dropped-sample count.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥ 4.
- `CNT_W`, 16: width of the dropped-sample counter.
- `ap_clk` in 1: sole clock; all state updates on the rising edge.
- `ap_rst_n` in 1: reset, asynchronous assert, active-low; clears all state.
- `adc_data` in 10: unsigned ADC sample, 0..1023.
- `adc_valid` in 1: `adc_data` is valid this cycle.
- `enable` in 1: writes are accepted only while this is high.
- `flush` in 1: synchronous clear of pointers and level.
- `clear_ovf` in 1: synchronous clear of `overflow` and `drop_cnt`.
- `datain_V_dout` out 10: signed two's-complement head sample.
- `datain_V_empty_n` out 1: high when the FIFO holds at least one entry.
- `datain_V_read` in 1: consumer pop strobe.
- `level` out log2(DEPTH)+1: current number of stored entries.
- `full` out 1: `level == DEPTH`.
- `overflow` out 1: sticky; a sample was dropped.
- `drop_cnt` out CNT_W: number of dropped samples, saturating.

## Operation
- Conversion on write: stored = `adc_data` with bit 9 inverted. This equals `adc_data` − 512 as signed 10-bit (0 → −512, 512 → 0, 1023 → +511).
- Write attempt: `adc_valid && enable`.
- Read: `datain_V_read && datain_V_empty_n`. A read strobe while empty is ignored and has no side effects.
- Accepted write: the attempt is accepted if not full, or if full with an accepted read in the same cycle.
  - An accepted write stores the sample at the write pointer and increments the pointer modulo DEPTH.
- Rejected write: full and no read in the same cycle.
  - The sample is discarded and `overflow` is set.
  - `drop_cnt` increments, saturating at 2^CNT_W − 1.
- Accepted read: increments the read pointer modulo DEPTH.
- `level` update: +1 on write only, −1 on read only, unchanged when both or neither occur.
- Pointer wrap: pointers carry an extra MSB for full/empty disambiguation, or `level` is the reference; the choice is free.
- Empty with a simultaneous write attempt: the write is accepted and the read is not (because `empty_n` was 0).
- `datain_V_dout`: equals the entry at the read pointer when `empty_n` = 1, and is forced to 0 when `empty_n` = 0.
- `flush`:
  - Sets both pointers and `level` to 0 at the next edge.
  - Has priority over any same-cycle write or read; the concurrent sample is discarded without counting as overflow.
  - `overflow` and `drop_cnt` are not affected.
- `clear_ovf`: clears `overflow` and `drop_cnt`. If a drop occurs in the same cycle, the result is `overflow` = 1 and `drop_cnt` = 1.
- Deasserting `enable` blocks new writes; the consumer may continue to drain.

## Timing
- Reset values: `datain_V_dout` = 0, `datain_V_empty_n` = 0, `level` = 0, `full` = 0, `overflow` = 0, `drop_cnt` = 0, pointers = 0.
- Reset assertion forces all outputs low immediately (asynchronous), including mid-transfer. The first write is possible on the first edge after deassertion.
- Write latency: a sample accepted at edge N is visible on `datain_V_dout` and `empty_n` = 1 in the cycle after edge N. There is no bypass from `adc_data` to `dout`.
- Read: the consumer samples `dout` in the cycle it asserts `read`. The next entry, or empty, appears after that edge.
- Sustained throughput: one write plus one read per cycle with `level` constant.
- `empty_n`, `full`, `level`, `overflow` and `drop_cnt` are registered. `datain_V_dout` is the memory head gated by registered `empty_n`.
- Memory: a register array or distributed RAM with asynchronous read is permitted.

## Test plan
- Reset check: assert `ap_rst_n` = 0 mid-stream with `level` = 5 → all outputs 0 within the same cycle. After release, `empty_n` stays 0 until the first write.
- Conversion: write 0, 512, 1023, 700 → reads return −512, 0, +511, +188 in order. Each sample is visible one cycle after its write.
- Fill and overflow:
  - DEPTH = 16; write 20 samples with no reads → `full` = 1 after the 16th, `overflow` = 1, `drop_cnt` = 4.
  - Reads then return only the first 16 samples.
  - `clear_ovf` → `overflow` = 0, `drop_cnt` = 0.
- Boundary cases:
  - Full with simultaneous write and read → no drop, `level` stays 16.
  - Empty with `read` = 1 → `level` stays 0, no pointer change.
  - Empty with simultaneous write and read → `level` = 1.
- Wrap-around: stream 100 samples with writes every cycle and reads every cycle, starting after a preload of 3 → output sequence equals the input shifted by 3 entries, `level` = 3 throughout, no overflow.
- Flush: with `level` = 9, assert `flush` concurrently with a write → `level` = 0, `empty_n` = 0, `drop_cnt` unchanged. The next write is read back correctly.
